ann_load_sequencer: RTL and testbench

Front-end controller for the ANN inference core. It accepts a byte stream on a valid/ready interface and drives the core's byte-write port, image at addresses 0..IMG_BYTES-1 and parameters (weights/biases) directly after. It then pulses start, waits for done, and returns the captured class with a timeout guard. Image-only runs reuse previously loaded parameters.

---
 rtl/ann_load_sequencer_if.sv | 29 ++
 rtl/ann_load_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ann_load_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ann_load_sequencer_if.sv
// Stream-in and core-side bus bundle for the ANN load sequencer.
// master: the sequencer (drives s_ready, wr_*, start; samples s_valid/s_data, done, final_class).
// slave:  the byte source plus inference core on the far side.
interface ann_load_sequencer_if #(
  parameter int ADDR_W = 14
);
  // byte stream, valid/ready
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  // core memory write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  // core run control
  logic              start;
  logic              done;
  logic [3:0]        final_class;

  modport master (
    input  s_valid, s_data, done, final_class,
    output s_ready, wr_en, wr_addr, wr_data, start
  );

  modport slave (
    output s_valid, s_data, done, final_class,
    input  s_ready, wr_en, wr_addr, wr_data, start
  );
endinterface

// File: rtl/ann_load_sequencer.sv
// Loads image (+ optional params) from a byte stream into the ANN core, kicks it, returns the class.
// Latency: accepted byte -> write strobe 1 cycle; last write -> start 1 cycle; done -> result_valid 1 cycle.
// Backpressure: s_ready is high only in LOAD; 1 byte/cycle sustained, bubbles on s_valid allowed.
// Ports: clk/rst_n (async active-low); cmd_load_all/cmd_load_img command pulses; bus = stream +
//        core write/start/done signals; result_valid/result_class, busy, params_loaded, err_code status.
module ann_load_sequencer #(
  parameter int IMG_BYTES      = 784,
  parameter int PARAM_BYTES    = 12730,
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_load_all,
  input  logic                 cmd_load_img,
  ann_load_sequencer_if.master bus,
  output logic                 result_valid,
  output logic [3:0]           result_class,
  output logic                 busy,
  output logic                 params_loaded,
  output logic [1:0]           err_code
);

  // One extra bit on the address counter so limit (up to 2^ADDR_W) compares without wrap.
  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LIM_ALL  = CW'(IMG_BYTES + PARAM_BYTES);
  localparam logic [CW-1:0] LIM_IMG  = CW'(IMG_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_KICK = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NOPARAM = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [CW-1:0]     addr_q,   addr_d;
  logic [CW-1:0]     limit_q,  limit_d;
  logic [TW-1:0]     tmo_q,    tmo_d;
  logic [1:0]        err_q,    err_d;
  logic              params_q, params_d;
  logic              wr_en_q,  wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rv_q,     rv_d;
  logic [3:0]        rc_q,     rc_d;

  logic          s_ready_w;
  logic          accept;
  logic          last_beat;
  logic [TW-1:0] tmo_inc;

  assign s_ready_w = (state_q == S_LOAD);
  assign accept    = bus.s_valid & s_ready_w;
  assign last_beat = (addr_q == (limit_q - CW'(1)));
  assign tmo_inc   = tmo_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    limit_d   = limit_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    params_d  = params_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rv_d      = 1'b0;
    rc_d      = rc_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (cmd_load_all) begin
          // Params get overwritten, so they are invalid until the last param byte lands.
          err_d    = ERR_NONE;
          params_d = 1'b0;
          limit_d  = LIM_ALL;
          addr_d   = '0;
          state_d  = S_LOAD;
        end else if (cmd_load_img) begin
          if (params_q) begin
            err_d   = ERR_NONE;
            limit_d = LIM_IMG;
            addr_d  = '0;
            state_d = S_LOAD;
          end else begin
            err_d = ERR_NOPARAM;
          end
        end
      end

      S_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q[ADDR_W-1:0];
          wr_data_d = bus.s_data;
          addr_d    = addr_q + CW'(1);
          if (last_beat) begin
            state_d = S_KICK;
            if (limit_q == LIM_ALL) begin
              params_d = 1'b1;
            end
          end
        end
      end

      S_KICK: begin
        // KICK spans the final write cycle plus the start cycle, so start lands
        // exactly one cycle after the last write strobe.
        tmo_d = '0;
        if (!wr_en_q) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.done) begin
          rv_d    = 1'b1;
          rc_d    = bus.final_class;
          state_d = S_IDLE;
        end else if (tmo_inc == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      limit_q   <= '0;
      tmo_q     <= '0;
      err_q     <= ERR_NONE;
      params_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rv_q      <= 1'b0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      limit_q   <= limit_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      params_q  <= params_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rv_q      <= rv_d;
      rc_q      <= rc_d;
    end
  end

  assign bus.s_ready   = s_ready_w;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.start     = (state_q == S_KICK) && !wr_en_q;

  assign result_valid  = rv_q;
  assign result_class  = rc_q;
  assign busy          = (state_q != S_IDLE);
  assign params_loaded = params_q;
  assign err_code      = err_q;

endmodule

// File: tb/tb_ann_load_sequencer.sv
// Bench for ann_load_sequencer: random byte streams against an address/data reference queue,
// plus command/result/timeout rules tracked by a small behavioural model.
module tb_ann_load_sequencer;
  localparam int IMG = 784;
  localparam int PAR = 12730;
  localparam int AW  = 14;
  localparam int TMO = 100;
  localparam int ALL = IMG + PAR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_load_all = 1'b0;
  logic       cmd_load_img = 1'b0;
  logic       result_valid;
  logic [3:0] result_class;
  logic       busy;
  logic       params_loaded;
  logic [1:0] err_code;

  ann_load_sequencer_if #(.ADDR_W(AW)) bus ();

  ann_load_sequencer #(
    .IMG_BYTES(IMG), .PARAM_BYTES(PAR), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_load_all(cmd_load_all), .cmd_load_img(cmd_load_img),
    .bus(bus),
    .result_valid(result_valid), .result_class(result_class),
    .busy(busy), .params_loaded(params_loaded), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: every accepted byte becomes one expected write {addr, data}, in order.
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] e;
  int            exp_addr = 0;

  // Behavioural model of the status outputs.
  bit m_pl = 1'b0;
  int m_err = 0;
  int m_class = 0;

  int wr_cnt = 0, start_cnt = 0, rv_cnt = 0;
  int last_wr_cyc = 0, start_cyc = 0, rv_cyc = 0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, e[AW+7:8]);
        chk("wr_data", bus.wr_data, e[7:0]);
      end
    end
    if (bus.start) begin
      start_cnt++;
      start_cyc = cyc;
      chk("start_gap", cyc - last_wr_cyc, 1);
    end
    if (result_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
  end

  task automatic issue(input bit all, input bit img);
    @(posedge clk); #1;
    cmd_load_all = all;
    cmd_load_img = img;
    @(posedge clk); #1;
    cmd_load_all = 1'b0;
    cmd_load_img = 1'b0;
    exp_addr = 0;
    if (all) begin
      m_err = 0;
      m_pl  = 1'b0;
    end else if (img) begin
      m_err = m_pl ? 0 : 2;
    end
  endtask

  // gap: percent of idle cycles on s_valid; poke_at: byte index at which both
  // commands are pulsed mid-load (-1 for never).
  task automatic send(input int n, input int gap, input int poke_at);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 4 * n + 100) begin
      @(posedge clk); #1;
      guard++;
      cmd_load_all = (sent == poke_at);
      cmd_load_img = (sent == poke_at);
      if (gap > 0 && $urandom_range(99) < gap) begin
        bus.s_valid = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom);
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({AW'(exp_addr), bus.s_data});
        exp_addr++;
        sent++;
      end
    end
    if (sent < n) chk("send_budget", sent, n);
    @(posedge clk); #1;
    bus.s_valid  = 1'b0;
    cmd_load_all = 1'b0;
    cmd_load_img = 1'b0;
  endtask

  task automatic wait_start(input int n0);
    int k = 0;
    while (start_cnt == n0 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("start_seen", start_cnt - n0, 1);
  endtask

  task automatic finish_run(input int cls);
    int d_edge;
    int rv0;
    rv0 = rv_cnt;
    @(posedge clk); #1;
    bus.done = 1'b1;
    bus.final_class = 4'(cls);
    d_edge = cyc + 1;
    @(posedge clk); #1;
    bus.done = 1'b0;
    @(negedge clk); #1;
    m_class = cls;
    chk("rv_pulse", rv_cnt - rv0, 1);
    chk("rv_cycle", rv_cyc, d_edge);
    chk("result_class", result_class, m_class);
    chk("busy_after_done", busy, 0);
    @(negedge clk); #1;
    chk("rv_oneshot", rv_cnt - rv0, 1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_s_ready"}, bus.s_ready, 0);
    chk({p, "_wr_en"}, bus.wr_en, 0);
    chk({p, "_wr_addr"}, bus.wr_addr, 0);
    chk({p, "_wr_data"}, bus.wr_data, 0);
    chk({p, "_start"}, bus.start, 0);
    chk({p, "_rv"}, result_valid, 0);
    chk({p, "_class"}, result_class, 0);
    chk({p, "_params"}, params_loaded, 0);
    chk({p, "_err"}, err_code, 0);
  endtask

  task automatic no_param_run(input string p);
    int w0, s0;
    issue(1'b0, 1'b1);
    chk({p, "_err"}, err_code, m_err);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_s_ready"}, bus.s_ready, 0);
    w0 = wr_cnt;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    #1;
    chk({p, "_no_wr"}, wr_cnt - w0, 0);
    chk({p, "_no_start"}, start_cnt - s0, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0, rv0, k, idle_cyc, s_at;
    bus.s_valid = 1'b0;
    bus.s_data = 8'd0;
    bus.done = 1'b0;
    bus.final_class = 4'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // image-only without params
    no_param_run("noparam");

    // full load, gapless
    issue(1'b1, 1'b0);
    chk("full_err_clear", err_code, m_err);
    chk("full_params_clr", params_loaded, m_pl);
    chk("full_busy", busy, 1);
    w0 = wr_cnt; s0 = start_cnt;
    send(ALL, 0, -1);
    wait_start(s0);
    m_pl = 1'b1;
    chk("full_wr_count", wr_cnt - w0, ALL);
    chk("full_exp_left", exp_q.size(), 0);
    chk("full_params", params_loaded, m_pl);
    repeat (20) @(posedge clk);
    finish_run(6);
    chk("full_start_once", start_cnt - s0, 1);

    // image-only reuse with random gaps
    issue(1'b0, 1'b1);
    chk("img_err", err_code, m_err);
    w0 = wr_cnt; s0 = start_cnt;
    send(IMG, 30, -1);
    wait_start(s0);
    chk("img_wr_count", wr_cnt - w0, IMG);
    chk("img_exp_left", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    finish_run(3);
    chk("img_params_kept", params_loaded, m_pl);
    chk("img_start_once", start_cnt - s0, 1);

    // timeout, with commands pulsed while waiting for done
    issue(1'b0, 1'b1);
    w0 = wr_cnt; s0 = start_cnt; rv0 = rv_cnt;
    send(IMG, 50, -1);
    wait_start(s0);
    s_at = start_cyc;
    @(posedge clk); #1;
    cmd_load_all = 1'b1; cmd_load_img = 1'b1;
    @(posedge clk); #1;
    cmd_load_all = 1'b0; cmd_load_img = 1'b0;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    idle_cyc = cyc;
    m_err = 1;
    chk("tmo_cycles", idle_cyc - s_at, TMO);
    chk("tmo_err", err_code, m_err);
    chk("tmo_no_rv", rv_cnt - rv0, 0);
    chk("tmo_class", result_class, m_class);
    chk("tmo_params", params_loaded, m_pl);
    chk("tmo_wr_count", wr_cnt - w0, IMG);

    // done while idle is ignored
    rv0 = rv_cnt;
    @(posedge clk); #1;
    bus.done = 1'b1; bus.final_class = 4'd9;
    @(posedge clk); #1;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_done_rv", rv_cnt - rv0, 0);
    chk("idle_done_class", result_class, m_class);
    chk("idle_done_busy", busy, 0);

    // both commands together -> full load; commands mid-load ignored
    issue(1'b1, 1'b1);
    chk("cont_err", err_code, m_err);
    chk("cont_params_clr", params_loaded, m_pl);
    chk("cont_busy", busy, 1);
    w0 = wr_cnt; s0 = start_cnt;
    send(ALL, 0, 1000);
    wait_start(s0);
    m_pl = 1'b1;
    chk("cont_wr_count", wr_cnt - w0, ALL);
    chk("cont_exp_left", exp_q.size(), 0);
    chk("cont_params", params_loaded, m_pl);
    repeat (10) @(posedge clk);
    finish_run(12);

    // asynchronous reset in the middle of a full load
    issue(1'b1, 1'b0);
    send(5000, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    m_pl = 1'b0; m_err = 0; m_class = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    no_param_run("postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
